cp0_param: RTL



---
 rtl/cp0_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cp0_param.sv
// rtl/cp0_param.sv - parametrised coprocessor-0 with interrupt arbitration and Count/Compare timer
//
// Sits beside the M stage of the five-stage pipeline. It arbitrates external
// interrupt lines and the on-chip timer against synchronous M-stage
// exceptions. On a take it records EPC/Cause/BD and raises EXL. It also
// services mfc0 reads, mtc0 writes and eret.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   addr, we, wdata      CP0 register number and mtc0 write strobe/data
//   rdata                mfc0 read data, combinational from addr (pre-write value)
//   pc_m, bd_m, m_valid  PC, delay-slot flag and valid bit of the M instruction
//   exc_valid, exc_code  synchronous exception raised by the M instruction
//   hwint                level-sensitive external interrupt lines
//   eret                 eret in M, clears EXL
//   req                  take exception/interrupt this cycle (flushes F..M)
//   vec_out              handler entry address
//   epc_out              current EPC, eret target
module cp0_param #(
  parameter int          HWINT_W = 6,
  parameter logic [31:0] EXC_VEC = 32'h0000_4180,
  parameter logic [31:0] PRID    = 32'h0000_2019
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [31:0]        pc_m,
  input  logic               bd_m,
  input  logic               m_valid,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [HWINT_W-1:0] hwint,
  input  logic               eret,
  output logic               req,
  output logic [31:0]        vec_out,
  output logic [31:0]        epc_out
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // Status fields
  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;

  // Cause fields
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;

  logic [31:0]        epc;
  logic [31:0]        count;
  logic [31:0]        compare;
  logic               timer_pending;

  logic [HWINT_W-1:0] ip;
  logic               int_req;
  logic               exc_req;
  logic               sr_wr;
  logic               epc_wr;
  logic               count_wr;
  logic               compare_wr;
  logic [31:0]        epc_next;
  logic               timer_hit;

  // Live pending vector. The timer shares the top hardware line so that a
  // one-line configuration still has a timer interrupt.
  always_comb begin
    ip              = hwint;
    ip[HWINT_W-1]   = hwint[HWINT_W-1] | timer_pending;
  end

  assign int_req = m_valid & sr_ie & ~sr_exl & (|(ip & sr_im));
  assign exc_req = exc_valid & ~sr_exl;
  assign req     = int_req | exc_req;

  assign sr_wr      = we && (addr == REG_SR);
  assign epc_wr     = we && (addr == REG_EPC);
  assign count_wr   = we && (addr == REG_COUNT);
  assign compare_wr = we && (addr == REG_COMPARE);

  // A delay-slot instruction restarts at its branch; EPC is always word aligned.
  assign epc_next  = (bd_m ? (pc_m - 32'd4) : pc_m) & 32'hFFFF_FFFC;

  // Compare == 0 disables the timer.
  assign timer_hit = (count == compare) && (compare != 32'd0);

  assign vec_out = EXC_VEC;
  assign epc_out = epc;

  // mfc0 read mux; no bypass of a same-cycle mtc0.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_SR: begin
        rdata[10 +: HWINT_W] = sr_im;
        rdata[1]             = sr_exl;
        rdata[0]             = sr_ie;
      end
      REG_CAUSE: begin
        rdata[31]            = cause_bd;
        rdata[10 +: HWINT_W] = cause_ip;
        rdata[6:2]           = cause_exc;
      end
      REG_EPC:     rdata = epc;
      REG_PRID:    rdata = PRID;
      default:     rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im         <= '0;
      sr_exl        <= 1'b0;
      sr_ie         <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip      <= '0;
      cause_exc     <= 5'd0;
      epc           <= 32'd0;
      count         <= 32'd0;
      compare       <= 32'd0;
      timer_pending <= 1'b0;
    end else begin
      // IM/IE are only ever written by mtc0; EXL resolves req > eret > mtc0.
      if (sr_wr) begin
        sr_im <= wdata[10 +: HWINT_W];
        sr_ie <= wdata[0];
      end
      if (req)
        sr_exl <= 1'b1;
      else if (eret)
        sr_exl <= 1'b0;
      else if (sr_wr)
        sr_exl <= wdata[1];

      cause_ip <= ip;

      // An interrupt outranks a simultaneous exception, so it reports ExcCode 0.
      if (req) begin
        cause_bd  <= bd_m;
        cause_exc <= int_req ? 5'd0 : exc_code;
        epc       <= epc_next;
      end else if (epc_wr) begin
        epc <= wdata;
      end

      count <= count_wr ? wdata : (count + 32'd1);

      if (compare_wr)
        compare <= wdata;

      // Writing Compare acknowledges the timer and beats a same-cycle hit.
      if (compare_wr)
        timer_pending <= 1'b0;
      else if (timer_hit)
        timer_pending <= 1'b1;
    end
  end

endmodule
